// File: rtl/switch_arbiter_pkg.sv
// Shared types and default sizing for the shared-light switch arbiter.
package switch_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ON       = 2'd1,
        COOLDOWN = 2'd2
    } arbState_t;

    localparam int DEF_N       = 4;
    localparam int DEF_TW      = 8;
    localparam int DEF_HOLDOFF = 2;

endpackage

// File: rtl/switch_arbiter_if.sv
// Button/light bundle between the requesters and the arbiter.
interface switch_arbiter_if
    import switch_arbiter_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int TW = DEF_TW
);
    logic [N-1:0]         button;
    logic [TW-1:0]        timeout_cfg;
    logic                 luz;
    logic [$clog2(N)-1:0] owner;
    logic                 owner_valid;
    logic [N-1:0]         grant;

    modport master (
        output button, timeout_cfg,
        input  luz, owner, owner_valid, grant
    );

    modport slave (
        input  button, timeout_cfg,
        output luz, owner, owner_valid, grant
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or after last+1, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic          any,
    output logic [LW-1:0] idx
);

    // Scan farthest-first so the closest candidate after last overwrites.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[LW'(last + LW'(k))]) idx = LW'(last + LW'(k));
        end
    end

endmodule

// File: rtl/switch_arbiter.sv
// Shared-light arbiter: one owner at a time, owner press or timeout releases,
// then a fixed holdoff before the next grant.
module switch_arbiter
    import switch_arbiter_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int TW      = DEF_TW,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input logic             clk,
    input logic             reset,
    switch_arbiter_if.slave bus
);

    localparam int LW = $clog2(N);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    arbState_t     state, stateNxt;
    logic [N-1:0]  buttonQ, press;
    logic [TW-1:0] cnt, cntNxt;
    logic [HW-1:0] holdCnt, holdNxt;
    logic [LW-1:0] lastOwner, lastNxt, ownerR, ownerNxt, pickIdx;
    logic [N-1:0]  grantR, grantNxt;
    logic          luzR, ownerValidR, pickAny, expire;

    assign press  = bus.button & ~buttonQ;
    assign expire = (bus.timeout_cfg != '0) && (cnt == bus.timeout_cfg - TW'(1));

    rr_pick #(.N(N), .LW(LW)) uPick (
        .req  (press),
        .last (lastOwner),
        .any  (pickAny),
        .idx  (pickIdx)
    );

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        holdNxt  = holdCnt;
        grantNxt = '0;
        ownerNxt = ownerR;
        lastNxt  = lastOwner;
        case (state)
            IDLE: if (pickAny) begin
                stateNxt = ON;
                cntNxt   = '0;
                grantNxt = N'(1) << pickIdx;
                ownerNxt = pickIdx;
                lastNxt  = pickIdx;
            end
            ON: begin
                cntNxt = cnt + TW'(1);
                // Owner release and timeout on the same edge collapse into one exit.
                if (press[ownerR] || expire) begin
                    stateNxt = COOLDOWN;
                    holdNxt  = '0;
                end
            end
            COOLDOWN: begin
                if (holdCnt == HW'(HOLDOFF - 1)) stateNxt = IDLE;
                else                             holdNxt  = holdCnt + HW'(1);
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Button register resets to ones so a button held through reset never presses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            buttonQ     <= '1;
            cnt         <= '0;
            holdCnt     <= '0;
            lastOwner   <= LW'(N - 1);
            ownerR      <= '0;
            grantR      <= '0;
            luzR        <= 1'b0;
            ownerValidR <= 1'b0;
        end else begin
            state       <= stateNxt;
            buttonQ     <= bus.button;
            cnt         <= cntNxt;
            holdCnt     <= holdNxt;
            lastOwner   <= lastNxt;
            ownerR      <= ownerNxt;
            grantR      <= grantNxt;
            luzR        <= (stateNxt == ON);
            ownerValidR <= (stateNxt == ON);
        end
    end

    assign bus.luz         = luzR;
    assign bus.owner_valid = ownerValidR;
    assign bus.owner       = ownerR;
    assign bus.grant       = grantR;

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter with hand-computed expectations.
module tb_switch_arbiter;
    import switch_arbiter_pkg::*;

    localparam int N       = 4;
    localparam int TW      = 8;
    localparam int HOLDOFF = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    switch_arbiter_if #(.N(N), .TW(TW)) bus ();

    switch_arbiter #(.N(N), .TW(TW), .HOLDOFF(HOLDOFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner idx toggles its button to release, then wait out the holdoff.
    task automatic dropLight(input int idx);
        bus.button = '0;
        tick();
        bus.button = 4'(1 << idx);
        tick();
        chk("drop luz", 32'(bus.luz), 0);
        bus.button = '0;
        tick();
        tick();
        chk("drop idle luz", 32'(bus.luz), 0);
    endtask

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};
        bus.button      = '0;
        bus.timeout_cfg = '0;

        // Reset state
        #12;
        chk("rst luz", 32'(bus.luz), 0);
        chk("rst owner_valid", 32'(bus.owner_valid), 0);
        chk("rst grant", 32'(bus.grant), 0);
        chk("rst owner", 32'(bus.owner), 0);
        reset = 1'b0;
        tick();

        // Basic grant, owner release, presses ignored during cooldown
        bus.button = 4'b0001;
        tick();
        chk("s1 grant", 32'(bus.grant), 32'h1);
        chk("s1 luz", 32'(bus.luz), 1);
        chk("s1 owner", 32'(bus.owner), 0);
        chk("s1 owner_valid", 32'(bus.owner_valid), 1);
        bus.button = '0;
        tick();
        chk("s1 grant pulse", 32'(bus.grant), 0);
        chk("s1 luz held", 32'(bus.luz), 1);
        bus.button = 4'b0001;
        tick();
        chk("s1 release luz", 32'(bus.luz), 0);
        chk("s1 release ov", 32'(bus.owner_valid), 0);
        chk("s1 owner hold", 32'(bus.owner), 0);
        bus.button = 4'b0010;
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("s1 cooldown luz", 32'(bus.luz), 0);
            chk("s1 cooldown grant", 32'(bus.grant), 0);
        end
        bus.button = '0;
        tick();
        chk("s1 no late grant", 32'(bus.grant), 0);

        // Round robin across simultaneous presses
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.button = 4'b1111;
            tick();
            chk("rr grant", 32'(bus.grant), 32'(1 << seq[i]));
            chk("rr owner", 32'(bus.owner), 32'(seq[i]));
            dropLight(seq[i]);
        end

        // Timeout of 5: five cycles on, two off, then idle
        bus.timeout_cfg = 8'd5;
        bus.button      = 4'b0100;
        tick();
        chk("to grant", 32'(bus.grant), 32'h4);
        bus.button = '0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk("to luz", 32'(bus.luz), (t < 5) ? 32'd1 : 32'd0);
        end
        tick();
        bus.button = 4'b0010;
        tick();
        chk("to idle grant", 32'(bus.grant), 32'h2);

        // Owner 1 release coincides with its timeout
        bus.button = '0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk("co luz", 32'(bus.luz), 1);
        end
        bus.button = 4'b0010;
        tick();
        chk("co exit luz", 32'(bus.luz), 0);
        chk("co exit grant", 32'(bus.grant), 0);
        bus.timeout_cfg = '0;
        tick();
        chk("co hold luz", 32'(bus.luz), 0);
        chk("co hold grant", 32'(bus.grant), 0);
        tick();
        chk("co idle grant", 32'(bus.grant), 0);
        bus.button = 4'b1000;
        tick();
        chk("co next grant", 32'(bus.grant), 32'h8);
        chk("co next owner", 32'(bus.owner), 3);
        dropLight(3);

        // Button held through reset never presses
        bus.button = 4'b1000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("held grant", 32'(bus.grant), 0);
            chk("held luz", 32'(bus.luz), 0);
        end
        bus.button = '0;
        tick();
        bus.button = 4'b1000;
        tick();
        chk("held repress grant", 32'(bus.grant), 32'h8);
        chk("held repress owner", 32'(bus.owner), 3);

        // Asynchronous reset while the light is on
        #3;
        reset = 1'b1;
        #1;
        chk("async luz", 32'(bus.luz), 0);
        chk("async owner_valid", 32'(bus.owner_valid), 0);
        bus.button = '0;
        tick();
        reset = 1'b0;
        tick();

        // Timeout lowered below the running count wraps instead of expiring
        bus.button = 4'b0001;
        tick();
        chk("wrap grant", 32'(bus.grant), 32'h1);
        bus.button      = '0;
        bus.timeout_cfg = 8'd3;
        tick();
        tick();
        bus.timeout_cfg = 8'd2;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("wrap luz", 32'(bus.luz), 1);
        end
        bus.timeout_cfg = '0;
        dropLight(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_arbiter.md
SWITCH_ARBITER -- requirements
Module: switch_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- N, 4, number of requesters (buttons); power of two, 2..8.
- TW, 8, width of the timeout counter and of timeout_cfg.
- HOLDOFF, 2, cycles the light stays off after a release, before a new grant; >= 1.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on posedge.
- reset, in, 1, asynchronous, active-high reset.
- button, in, N, per-requester level button inputs, synchronous to clk.
- timeout_cfg, in, TW, ON-state auto-off limit in cycles; 0 disables the timeout.
- luz, out, 1, shared light; 1 = on.
- owner, out, log2(N), index of the current owner; valid only while owner_valid = 1.
- owner_valid, out, 1, 1 while in state ON.
- grant, out, N, one-hot single-cycle pulse on the edge a requester is granted.

Function
REQ-003 press[i] SHALL be button[i] & ~button_q[i], where button_q is button registered on every posedge; a held button SHALL produce exactly one press.
REQ-004 The FSM SHALL have three states: IDLE (luz = 0), ON (luz = 1), COOLDOWN (luz = 0); luz, owner_valid and grant SHALL be registered outputs.
REQ-005 IDLE: on an edge where any press is 1, the FSM SHALL go to ON, load owner, set luz = 1 and pulse grant[owner] for one cycle, all on that same edge (zero added latency beyond the input register).
REQ-006 Simultaneous presses in IDLE SHALL be resolved round-robin: the winner is the first pressing index at or after (last_owner + 1) mod N; last_owner SHALL update to the winner on every grant.
REQ-007 ON: a press from owner SHALL release the light (go to COOLDOWN); presses from any other requester SHALL be ignored and SHALL NOT be queued.
REQ-008 ON: a TW-bit counter SHALL clear on entry and increment each cycle in ON; when timeout_cfg != 0 and counter == timeout_cfg - 1, the next edge SHALL go to COOLDOWN, giving exactly timeout_cfg cycles with luz = 1.
REQ-009 If an owner release and a timeout occur on the same edge, the FSM SHALL enter COOLDOWN once, with no extra effect.
REQ-010 A change to timeout_cfg during ON SHALL take effect on the next compare; a value at or below the current count SHALL cause the counter to wrap modulo 2^TW, not to expire immediately.
REQ-011 COOLDOWN SHALL last exactly HOLDOFF cycles, ignoring all presses, then go to IDLE; a button held across COOLDOWN SHALL NOT generate a new press.
REQ-012 owner SHALL hold its last value outside ON; grant SHALL be 0 on every cycle without a grant.

Reset
REQ-013 While reset = 1, asynchronously: state = IDLE, luz = 0, owner_valid = 0, grant = 0, owner = 0, last_owner = N-1 (so requester 0 has first priority), button_q = all ones (a button held through reset does not press), and the counters = 0.
REQ-014 Reset asserted mid-ON or mid-COOLDOWN SHALL force luz = 0 immediately, without waiting for a clock edge.

Structure
REQ-015 A shared package SHALL hold the state enumeration (IDLE, ON, COOLDOWN) and the default values of N, TW and HOLDOFF.
REQ-016 The round-robin priority picker SHALL be a separate combinational sub-module, rr_pick (inputs: req, last; outputs: any, idx); the FSM, counters and edge detect SHALL stay in switch_arbiter.

Verification
REQ-017 The bench SHALL be self-checking against a behavioural model and SHALL cover these directed scenarios:
- Reset, then button = 4'b0001 for 1 cycle -> grant = 4'b0001 for one cycle, luz = 1, owner = 0; a second press of bit 0 -> luz = 0, and button = 4'b0010 during the next 2 cycles is ignored.
- IDLE, button = 4'b1111 on one edge, repeated after each release -> owner sequence 0, 1, 2, 3, 0.
- timeout_cfg = 5, press bit 2 -> luz = 1 for exactly 5 cycles, then 0 for 2 cycles, then IDLE.
- Owner 1 presses again on the same edge its timeout expires -> a single COOLDOWN of 2 cycles, and no new grant.
- Bit 3 held high through reset and afterwards -> no grant until bit 3 is released and pressed again.
- Reset asserted between clock edges while luz = 1 -> luz = 0 before the next posedge, and owner_valid = 0.
